uart_tx_scheduler: RTL and testbench

//  Shares one async_transmitter byte port between NUM_REQ byte-stream requesters.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rr_arbiter.sv | 33 +++
 rtl/uart_tx_scheduler.sv | 122 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared widths, FSM state type and round-robin helper for the UART
// transmit scheduler and its arbiter.
package uart_pkg;

    localparam int BYTE_W  = 8;
    localparam int GRANT_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DRAIN,
        GAP
    } state_t;

    // Index that follows idx in a ring of n requesters.
    function automatic logic [GRANT_W-1:0] rr_next(input logic [GRANT_W-1:0] idx,
                                                   input int                 n);
        if (int'(idx) + 1 >= n) return '0;
        return idx + GRANT_W'(1);
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after the
// priority pointer, wrapping around, as a one-hot vector and an index.
module uart_rr_arbiter import uart_pkg::*; #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [GRANT_W-1:0] ptr_i,
    output logic [NUM_REQ-1:0] grant_oh_o,
    output logic [GRANT_W-1:0] grant_idx_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0] idx;

    // NOTE: every output and temporary gets a default before the loop, otherwise the
    // "no request" path would infer latches.
    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        idx         = '0;
        // Scan from the farthest offset down so the nearest hit overwrites the rest.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
            if (req_i[idx]) begin
                grant_oh_o      = '0;
                grant_oh_o[idx] = 1'b1;
                grant_idx_o     = GRANT_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one async_transmitter byte port among NUM_REQ byte streams: packet-level
// round-robin with a per-grant byte cap and idle baud ticks between packets.
module uart_tx_scheduler import uart_pkg::*; #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_PKT_LEN = 16,
    parameter int GAP_TICKS   = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      baud_tick,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_start,
    output logic [BYTE_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic [GRANT_W-1:0]        grant_id,
    output logic                      active
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t              state_q, state_d;
    logic [GRANT_W-1:0]  grant_q, grant_d;
    logic [GRANT_W-1:0]  ptr_q, ptr_d;
    logic [7:0]          byte_cnt_q, byte_cnt_d;
    logic [3:0]          gap_cnt_q, gap_cnt_d;
    logic [BYTE_W-1:0]   data_q, data_d;
    logic                last_q, last_d;

    logic [NUM_REQ-1:0]  arb_oh;
    logic [GRANT_W-1:0]  arb_idx;
    logic [IDX_W-1:0]    grant_idx;

    uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .grant_oh_o  (arb_oh),
        .grant_idx_o (arb_idx)
    );

    assign grant_idx = grant_q[IDX_W-1:0];
    assign grant_id  = grant_q;
    assign tx_data   = data_q;
    assign tx_start  = (state_q == START);
    assign active    = (state_q != IDLE);

    // req_ready is combinational so the pop strobe coincides with the edge that captures the byte.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        data_d     = data_q;
        last_d     = last_q;
        req_ready  = '0;
        unique case (state_q)
            IDLE: begin
                if (enable && (|arb_oh) && !tx_busy) begin
                    grant_d    = arb_idx;
                    byte_cnt_d = '0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (req_valid[grant_idx]) begin
                    data_d               = req_data[grant_idx*BYTE_W +: BYTE_W];
                    last_d               = req_last[grant_idx];
                    req_ready[grant_idx] = 1'b1;
                    byte_cnt_d           = byte_cnt_q + 8'd1;
                    state_d              = START;
                end
            end
            START: begin
                // The transmitter only samples start on a baud tick, so hold until one is seen.
                if (baud_tick) state_d = DRAIN;
            end
            DRAIN: begin
                if (!tx_busy) begin
                    if (last_q || byte_cnt_q == 8'(MAX_PKT_LEN)) begin
                        ptr_d     = rr_next(grant_q, NUM_REQ);
                        gap_cnt_d = 4'(GAP_TICKS);
                        state_d   = GAP;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == 4'd0) state_d = IDLE;
                else if (baud_tick)    gap_cnt_d = gap_cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers take non-blocking assignments only; the async reset clears
    // everything, including the data register, so tx_data reads zero out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            data_q     <= data_d;
            last_q     <= last_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: a stand-in serial transmitter, queue-fed requesters
// and a packet-level arbitration model that predicts the byte/requester order.
module tb_uart_tx_scheduler;

    localparam int NUM_REQ     = 4;
    localparam int MAX_PKT_LEN = 16;
    localparam int GAP_TICKS   = 2;
    localparam int BAUD_DIV    = 16;

    typedef struct packed { logic last; logic [7:0] data; } item_t;
    typedef struct packed { logic [2:0] id; logic [7:0] data; } exp_t;

    logic                 clk       = 1'b0;
    logic                 reset_n   = 1'b0;
    logic                 enable    = 1'b0;
    logic                 baud_tick = 1'b0;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [8*NUM_REQ-1:0] req_data  = '0;
    logic [NUM_REQ-1:0]   req_last  = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic [2:0]           grant_id;
    logic                 active;

    int total = 0;
    int bad   = 0;

    item_t      src_q [NUM_REQ][$];
    exp_t       exp_q [$];
    logic [7:0] got_data [$];
    logic [2:0] got_id [$];
    int         model_ptr = 0;
    int         baud_cnt  = 0;
    int         ready_cnt [NUM_REQ];
    int         last_width = 0;

    uart_tx_scheduler #(
        .NUM_REQ(NUM_REQ), .MAX_PKT_LEN(MAX_PKT_LEN), .GAP_TICKS(GAP_TICKS)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .baud_tick (baud_tick),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .active    (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Free-running baud strobe; tests may re-phase it through baud_cnt.
    initial forever begin
        @(posedge clk);
        #1;
        baud_cnt  = (baud_cnt + 1) % BAUD_DIV;
        baud_tick = (baud_cnt == 0);
    end

    // Transmitter stand-in: start bit, 8 data bits LSB first, stop bit, busy until the tick after stop.
    logic       txd;
    logic [3:0] tx_bit;
    logic [7:0] tx_shift;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_busy  <= 1'b0;
            txd      <= 1'b1;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else if (!tx_busy) begin
            if (tx_start && baud_tick) begin
                tx_busy  <= 1'b1;
                txd      <= 1'b0;
                tx_bit   <= '0;
                tx_shift <= tx_data;
            end
        end else if (baud_tick) begin
            tx_bit <= tx_bit + 4'd1;
            if (tx_bit < 4'd8)       txd <= tx_shift[tx_bit[2:0]];
            else if (tx_bit == 4'd8) txd <= 1'b1;
            else                     tx_busy <= 1'b0;
        end
    end

    task automatic drive_sources();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_q[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = src_q[i][0].data;
                req_last[i]        = src_q[i][0].last;
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    // Requesters pop their head byte on the edge that follows a sampled req_ready.
    initial begin
        logic [NUM_REQ-1:0] ready_seen;
        forever begin
            @(negedge clk);
            ready_seen = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++)
                if (ready_seen[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            drive_sources();
        end
    end

    // Packet-level model: pick the first non-empty queue at/after the pointer, send until
    // last or the cap, move the pointer past the winner; an empty queue mid-packet stalls.
    task automatic build_expected();
        item_t m [NUM_REQ][$];
        item_t it;
        int    g;
        int    idx;
        int    sent;
        for (int i = 0; i < NUM_REQ; i++) m[i] = src_q[i];
        forever begin
            g = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (model_ptr + k) % NUM_REQ;
                if (g < 0 && m[idx].size() > 0) g = idx;
            end
            if (g < 0) return;
            sent = 0;
            forever begin
                if (m[g].size() == 0) return;
                it = m[g].pop_front();
                exp_q.push_back({3'(g), it.data});
                sent++;
                if (it.last || sent == MAX_PKT_LEN) begin
                    model_ptr = (g + 1) % NUM_REQ;
                    break;
                end
            end
        end
    endtask

    // Compare process: every accepted byte against the model, plus per-cycle handshake rules.
    initial begin
        logic       prev_start;
        logic [7:0] prev_data;
        int         width;
        int         accepts;
        exp_t       e;
        prev_start = 1'b0;
        prev_data  = '0;
        width      = 0;
        accepts    = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_start = 1'b0;
                width      = 0;
                accepts    = 0;
                continue;
            end
            if (req_ready != '0) begin
                check("req_ready_onehot", 32'(req_ready), 32'(1) << grant_id);
                for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) ready_cnt[i]++;
            end
            if (tx_start) begin
                if (prev_start) check("tx_data_stable", 32'(tx_data), 32'(prev_data));
                width++;
                if (baud_tick && !tx_busy) begin
                    accepts++;
                    got_data.push_back(tx_data);
                    got_id.push_back(grant_id);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_byte: got=%0h from id %0d, none required", tx_data, grant_id);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte_data", 32'(tx_data), 32'(e.data));
                        check("byte_id", 32'(grant_id), 32'(e.id));
                    end
                end
            end else if (prev_start) begin
                check("frames_per_start", accepts, 1);
                last_width = width;
                width      = 0;
                accepts    = 0;
            end
            prev_start = tx_start;
            prev_data  = tx_data;
        end
    end

    task automatic clear_env();
        for (int i = 0; i < NUM_REQ; i++) begin
            src_q[i].delete();
            ready_cnt[i] = 0;
        end
        exp_q.delete();
        got_data.delete();
        got_id.delete();
        model_ptr = 0;
        drive_sources();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_env();
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        src_q[r].push_back({l, d});
    endtask

    task automatic start_round();
        build_expected();
        drive_sources();
    endtask

    task automatic wait_exp(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (active && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(active), 0);
    endtask

    task automatic wait_load(input string name, input int budget);
        int n = 0;
        @(negedge clk);
        while (req_ready == '0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(req_ready != '0), 1);
    endtask

    initial begin
        int n;
        int ticks;
        int low_seen;
        int act_cycles;

        @(posedge clk);
        #1;
        check("reset_tx_start", 32'(tx_start), 0);
        check("reset_tx_data", 32'(tx_data), 0);
        check("reset_req_ready", 32'(req_ready), 0);
        check("reset_grant_id", 32'(grant_id), 0);
        check("reset_active", 32'(active), 0);
        do_reset();

        // Three-byte packet from requester 0, then the inter-packet gap.
        push(0, 8'h55, 1'b0);
        push(0, 8'hA3, 1'b0);
        push(0, 8'h0F, 1'b1);
        start_round();
        enable = 1'b1;
        wait_exp("t1_drained", 2000);
        check("t1_ready_pulses", ready_cnt[0], 3);
        check("t1_bytes", {got_data[0], got_data[1], got_data[2]}, 32'h0055A30F);
        n = 0;
        while (!tx_busy && n < 50) begin @(negedge clk); n++; end
        while (tx_busy && n < 400) begin @(negedge clk); n++; end
        check("t1_frame_end", 32'(tx_busy), 0);
        ticks    = 0;
        low_seen = 0;
        n        = 0;
        while (active && n < 200) begin
            if (baud_tick) ticks++;
            if (!txd) low_seen++;
            @(negedge clk);
            n++;
        end
        check("t1_gap_ticks", ticks, GAP_TICKS);
        check("t1_gap_idle_high", low_seen, 0);
        check("t1_inactive", 32'(active), 0);

        // Requesters 1 and 2 both pending from reset with two packets each.
        enable = 1'b0;
        do_reset();
        push(1, 8'h11, 1'b0);
        push(1, 8'h12, 1'b1);
        push(1, 8'h13, 1'b1);
        push(2, 8'h21, 1'b1);
        push(2, 8'h22, 1'b1);
        start_round();
        enable = 1'b1;
        wait_exp("t2_drained", 4000);
        wait_idle("t2_idle", 200);
        check("t2_grant_order", {got_id[0], got_id[1], got_id[2], got_id[3], got_id[4]},
              32'b001_001_010_001_010);

        // Requester 3 streams 40 unterminated bytes while requester 0 has two short packets.
        for (int k = 0; k < 40; k++) push(3, 8'(8'h80 + k), 1'b0);
        push(0, 8'hC0, 1'b0);
        push(0, 8'hC1, 1'b1);
        push(0, 8'hC2, 1'b0);
        push(0, 8'hC3, 1'b1);
        got_data.delete();
        got_id.delete();
        start_round();
        wait_exp("t3_drained", 20000);
        check("t3_count", got_data.size(), 44);
        check("t3_cap_switch", {got_id[15], got_id[16], got_id[17], got_id[18]}, 32'b011_000_000_011);
        check("t3_req0_first", 32'(got_data[16]), 32'hC0);

        // tx_start width with the baud tick landing on the first vs. sixteenth START cycle.
        enable = 1'b0;
        do_reset();
        push(1, 8'h3C, 1'b1);
        start_round();
        enable = 1'b1;
        wait_load("t4_load_a", 200);
        #1;
        baud_cnt  = BAUD_DIV - 1;
        baud_tick = 1'b0;
        wait_idle("t4_idle_a", 600);
        check("t4_width_1", last_width, 1);
        push(2, 8'hC3, 1'b1);
        start_round();
        wait_load("t4_load_b", 200);
        #1;
        baud_cnt  = 0;
        baud_tick = 1'b0;
        wait_idle("t4_idle_b", 600);
        check("t4_width_16", last_width, 16);
        wait_exp("t4_drained", 10);

        // Reset while data bit 4 of the first frame is on the line.
        push(0, 8'hA5, 1'b0);
        push(0, 8'h5A, 1'b0);
        push(0, 8'hFF, 1'b1);
        start_round();
        n = 0;
        while (!(tx_busy && tx_bit == 4'd5) && n < 600) begin @(negedge clk); n++; end
        check("t5_reached_bit4", 32'(txd), 32'(1'b0));
        #2 reset_n = 1'b0;
        #1;
        check("t5_rst_tx_start", 32'(tx_start), 0);
        check("t5_rst_req_ready", 32'(req_ready), 0);
        check("t5_rst_active", 32'(active), 0);
        check("t5_rst_txd_high", 32'(txd), 1);
        clear_env();
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        push(0, 8'h66, 1'b0);
        push(0, 8'h99, 1'b1);
        push(1, 8'h77, 1'b1);
        start_round();
        wait_exp("t5_drained", 3000);
        wait_idle("t5_idle", 200);
        check("t5_after_reset", {got_data[0], got_data[1], got_data[2]}, 32'h006699_77);

        // enable drops after the first byte of a 5-byte packet.
        enable = 1'b0;
        do_reset();
        for (int k = 1; k <= 5; k++) push(0, 8'(k), k == 5);
        push(1, 8'hEE, 1'b1);
        start_round();
        enable = 1'b1;
        n = 0;
        while (got_data.size() < 1 && n < 300) begin @(negedge clk); n++; end
        enable = 1'b0;
        wait_idle("t6_idle", 3000);
        check("t6_count_disabled", got_data.size(), 5);
        act_cycles = 0;
        repeat (64) begin
            @(negedge clk);
            if (active || req_ready != '0) act_cycles++;
        end
        check("t6_no_grant", act_cycles, 0);
        enable = 1'b1;
        wait_exp("t6_drained", 600);
        check("t6_last_byte", 32'(got_data[got_data.size()-1]), 32'hEE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
